// File: rtl/pingpong_ram_scheduler_if.sv
// Manage bundle between the ping-pong scheduler (master) and the RAM write/read engines (slave).
// The err signal exists only when PPRS_ERR_CHK_EN is defined.
interface pingpong_ram_scheduler_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 en;
  logic                 wr_finish_0;
  logic                 wr_finish_1;
  logic                 rd_finish_0;
  logic                 rd_finish_1;
  logic                 wr_command;
  logic                 wr_ram_number;
  logic                 rd_command;
  logic                 rd_ram_number;
  logic                 wr_busy;
  logic                 rd_busy;
  logic [1:0]           bank_full;
  logic [CNT_WIDTH-1:0] frames_done;
`ifdef PPRS_ERR_CHK_EN
  logic                 err;
`endif

  modport master (
    input  en, wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1,
    output wr_command, wr_ram_number, rd_command, rd_ram_number,
           wr_busy, rd_busy, bank_full, frames_done
`ifdef PPRS_ERR_CHK_EN
    , output err
`endif
  );

  modport slave (
    output en, wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1,
    input  wr_command, wr_ram_number, rd_command, rd_ram_number,
           wr_busy, rd_busy, bank_full, frames_done
`ifdef PPRS_ERR_CHK_EN
    , input err
`endif
  );
endinterface

// File: rtl/pingpong_ram_scheduler.sv
// Ping-pong transpose buffer scheduler: per-bank EMPTY/WRITING/FULL/READING tracking with strictly
// alternating write and read jobs. Optional sticky protocol error output under PPRS_ERR_CHK_EN.
module pingpong_ram_scheduler #(
  parameter int CNT_WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  pingpong_ram_scheduler_if.master mgr
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'b00,
    BANK_WRITING = 2'b01,
    BANK_FULL    = 2'b10,
    BANK_READING = 2'b11
  } bank_state_t;

  bank_state_t          bank_r     [2];
  bank_state_t          bank_fin_s [2];
  bank_state_t          bank_nxt_s [2];
  logic                 wr_ptr_r;
  logic                 rd_ptr_r;
  logic [1:0]           wr_fin_s;
  logic [1:0]           rd_fin_s;
  logic                 wr_issue_s;
  logic                 rd_issue_s;
  logic                 rd_accept_s;

  logic                 wr_command_r;
  logic                 wr_ram_number_r;
  logic                 rd_command_r;
  logic                 rd_ram_number_r;
  logic                 wr_busy_r;
  logic                 rd_busy_r;
  logic [1:0]           bank_full_r;
  logic [CNT_WIDTH-1:0] frames_done_r;

  logic                 wr_ram_number_nxt_s;
  logic                 rd_ram_number_nxt_s;
  logic                 wr_busy_nxt_s;
  logic                 rd_busy_nxt_s;
  logic [1:0]           bank_full_nxt_s;
  logic [CNT_WIDTH-1:0] frames_done_nxt_s;

  // Finish pulses only advance a bank that is in the matching in-flight state.
  function automatic bank_state_t apply_finish(input bank_state_t cur, input logic wr_fin,
                                               input logic rd_fin);
    bank_state_t res;
    if (wr_fin && (cur == BANK_WRITING)) begin
      res = BANK_FULL;
    end else if (rd_fin && (cur == BANK_READING)) begin
      res = BANK_EMPTY;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  assign wr_fin_s = {mgr.wr_finish_1, mgr.wr_finish_0};
  assign rd_fin_s = {mgr.rd_finish_1, mgr.rd_finish_0};

  // Next-state: apply finishes first so a freed bank can be reissued on the very next edge.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      bank_fin_s[n] = apply_finish(bank_r[n], wr_fin_s[n], rd_fin_s[n]);
    end

    rd_accept_s = (rd_fin_s[0] && (bank_r[0] == BANK_READING)) ||
                  (rd_fin_s[1] && (bank_r[1] == BANK_READING));

    wr_issue_s = mgr.en && (bank_fin_s[0] != BANK_WRITING) && (bank_fin_s[1] != BANK_WRITING) &&
                 (bank_fin_s[wr_ptr_r] == BANK_EMPTY);
    rd_issue_s = mgr.en && (bank_fin_s[0] != BANK_READING) && (bank_fin_s[1] != BANK_READING) &&
                 (bank_fin_s[rd_ptr_r] == BANK_FULL);

    for (int n = 0; n < 2; n++) begin
      if (wr_issue_s && (wr_ptr_r == 1'(n))) begin
        bank_nxt_s[n] = BANK_WRITING;
      end else if (rd_issue_s && (rd_ptr_r == 1'(n))) begin
        bank_nxt_s[n] = BANK_READING;
      end else begin
        bank_nxt_s[n] = bank_fin_s[n];
      end
    end

    wr_ram_number_nxt_s = wr_issue_s ? wr_ptr_r : wr_ram_number_r;
    rd_ram_number_nxt_s = rd_issue_s ? rd_ptr_r : rd_ram_number_r;
    wr_busy_nxt_s       = (bank_nxt_s[0] == BANK_WRITING) || (bank_nxt_s[1] == BANK_WRITING);
    rd_busy_nxt_s       = (bank_nxt_s[0] == BANK_READING) || (bank_nxt_s[1] == BANK_READING);
    bank_full_nxt_s     = {(bank_nxt_s[1] == BANK_FULL), (bank_nxt_s[0] == BANK_FULL)};
    frames_done_nxt_s   = rd_accept_s ? (frames_done_r + CNT_WIDTH'(1)) : frames_done_r;
  end

  // State, pointer and registered output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_r[0]       <= BANK_EMPTY;
      bank_r[1]       <= BANK_EMPTY;
      wr_ptr_r        <= 1'b0;
      rd_ptr_r        <= 1'b0;
      wr_command_r    <= 1'b0;
      wr_ram_number_r <= 1'b0;
      rd_command_r    <= 1'b0;
      rd_ram_number_r <= 1'b0;
      wr_busy_r       <= 1'b0;
      rd_busy_r       <= 1'b0;
      bank_full_r     <= 2'b00;
      frames_done_r   <= '0;
    end else begin
      bank_r[0]       <= bank_nxt_s[0];
      bank_r[1]       <= bank_nxt_s[1];
      wr_ptr_r        <= wr_ptr_r ^ wr_issue_s;
      rd_ptr_r        <= rd_ptr_r ^ rd_issue_s;
      wr_command_r    <= wr_issue_s;
      wr_ram_number_r <= wr_ram_number_nxt_s;
      rd_command_r    <= rd_issue_s;
      rd_ram_number_r <= rd_ram_number_nxt_s;
      wr_busy_r       <= wr_busy_nxt_s;
      rd_busy_r       <= rd_busy_nxt_s;
      bank_full_r     <= bank_full_nxt_s;
      frames_done_r   <= frames_done_nxt_s;
    end
  end

  assign mgr.wr_command    = wr_command_r;
  assign mgr.wr_ram_number = wr_ram_number_r;
  assign mgr.rd_command    = rd_command_r;
  assign mgr.rd_ram_number = rd_ram_number_r;
  assign mgr.wr_busy       = wr_busy_r;
  assign mgr.rd_busy       = rd_busy_r;
  assign mgr.bank_full     = bank_full_r;
  assign mgr.frames_done   = frames_done_r;

`ifdef PPRS_ERR_CHK_EN
  logic err_r;
  logic illegal_s;

  // Any finish to a bank not in the matching state, or paired finishes, is a protocol violation.
  always_comb begin
    illegal_s = (wr_fin_s[0] && (bank_r[0] != BANK_WRITING)) ||
                (wr_fin_s[1] && (bank_r[1] != BANK_WRITING)) ||
                (rd_fin_s[0] && (bank_r[0] != BANK_READING)) ||
                (rd_fin_s[1] && (bank_r[1] != BANK_READING)) ||
                (&wr_fin_s) || (&rd_fin_s);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | illegal_s;
    end
  end

  assign mgr.err = err_r;
`endif

endmodule
